seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter PAT_LEN, default 4, SHALL set the pattern length in bits; legal range 2..16.
REQ-002 Parameter PAT_INIT, default 4'b1011 (PAT_LEN bits), SHALL be the pattern register value after reset.
REQ-003 Parameter CNT_W, default 8, SHALL set the match-counter width; legal range 1..16.
REQ-004 Port clk_bar  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 Port clr_bar  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006 Port x  input  1  SHALL be the serial data bit.
REQ-007 Port x_valid  input  1  SHALL qualify x; x SHALL be ignored when low.
REQ-008 Port overlap  input  1  SHALL select the detection mode: 1 = overlapping, 0 = non-overlapping.
REQ-009 Port load  input  1  SHALL request a pattern load.
REQ-010 Port pat_in  input  PAT_LEN  SHALL be the new pattern, with the MSB detected first.
REQ-011 Port z  output  1  SHALL be the registered match pulse.
REQ-012 Port match_cnt  output  CNT_W  SHALL be the saturating match count.

Function
REQ-013 The block SHALL keep a PAT_LEN-1 bit history shift register (newest bit at LSB) and a fill counter of 0..PAT_LEN-1 tracking the valid history bits.
REQ-014 On an edge with x_valid=1, a match SHALL be {history, x} == pattern with fill == PAT_LEN-1.
REQ-015 z SHALL be 1 for exactly the one cycle following the edge that sampled the completing bit (latency 1 clock), otherwise 0.
REQ-016 On each accepted bit, history SHALL shift in x and fill SHALL increment, saturating at PAT_LEN-1.
REQ-017 In overlapping mode, a match SHALL leave the history and fill intact, so the completing bits count toward the next match.
REQ-018 In non-overlapping mode, a match SHALL set fill to 0; the next match SHALL then need PAT_LEN fresh bits.
REQ-019 overlap SHALL be sampled every edge, and a change in overlap SHALL affect only matches completing on or after that edge.
REQ-020 With x_valid=0, history, fill and match_cnt SHALL hold, and z SHALL be 0 on the next cycle.
REQ-021 With load=1 at an edge, the block SHALL set pattern <= pat_in, fill <= 0, history <= 0, z <= 0 and match_cnt <= 0.
REQ-022 load SHALL take priority over x_valid at the same edge; that x SHALL be discarded.
REQ-023 match_cnt SHALL increment by 1 on each match and SHALL saturate at 2^CNT_W-1 (no wrap-around).

Reset
REQ-024 With clr_bar=0, the block SHALL immediately set z=0, match_cnt=0, history=0, fill=0 and pattern=PAT_INIT, independent of the clock.
REQ-025 A reset asserted mid-pattern SHALL discard partial progress, and the first match after release SHALL require PAT_LEN new bits.

Configuration
REQ-026 Macro SEQ_DETECTOR_PARAM_CNT_EN defined: the match counter SHALL be implemented as specified.
REQ-027 Macro SEQ_DETECTOR_PARAM_CNT_EN undefined: no counter register SHALL exist, and match_cnt SHALL be tied to 0; all other behaviour SHALL be unchanged.

Structure
REQ-028 Package seq_det_pkg SHALL hold the PAT_LEN/CNT_W legal-range constants, the default PAT_INIT, and the mode encodings OVL=1'b1 and NOVL=1'b0.
REQ-029 The history shift register plus fill counter SHALL be one sub-module, seq_shift_reg (parameter DEPTH=PAT_LEN-1; inputs shift_en, din, flush; outputs hist, full).
REQ-030 Out-of-range parameters SHALL be rejected at elaboration.

Verification (PAT_LEN=4, PAT_INIT=1011, CNT_W=8)
REQ-031 Overlapping: overlap=1, x_valid=1, x=1,0,1,1,0,1,1 -> z high in the cycles after bits 4 and 7; match_cnt=2.
REQ-032 Non-overlapping: overlap=0, same stream -> z only after bit 4; match_cnt=1.
REQ-033 Load: load=1, pat_in=0110 with x_valid=1, x=1 on the same edge -> x discarded, match_cnt=0; then 0,1,1,0 -> one z pulse.
REQ-034 Gaps and reset: stream 1,0,1 with x_valid=0 for 3 cycles, then 1 -> match. Separately, clr_bar=0 asynchronously after 1,0,1, then release and send 1 -> no match.
REQ-035 Saturation: CNT_W=2, overlap=1, stream 1011011011011 -> match_cnt goes 1,2,3 and stays 3.
REQ-036 Macro off: rerun the REQ-031 stimulus -> match_cnt stays 0, with z identical to REQ-031.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants for the serial pattern detector: parameter legal ranges,
// default pattern and detection-mode encodings.
package seq_det_pkg;
    localparam int PAT_LEN_MIN = 2;
    localparam int PAT_LEN_MAX = 16;
    localparam int CNT_W_MIN   = 1;
    localparam int CNT_W_MAX   = 16;

    localparam logic [3:0] PAT_INIT_DEF = 4'b1011;

    localparam logic OVL  = 1'b1;
    localparam logic NOVL = 1'b0;
endpackage

// File: rtl/seq_shift_reg.sv
// History shift register (newest bit at LSB) with a saturating fill counter
// that reports when DEPTH valid bits have been collected.
module seq_shift_reg #(
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             din,
    input  logic             flush,
    output logic [DEPTH-1:0] hist,
    output logic             full
);
    localparam int FW = $clog2(DEPTH + 1);

    logic [FW-1:0] fill;

    assign full = (fill == FW'(DEPTH));

    // Flush wins over shift; a flushed history is also zeroed so stale bits
    // never linger, though fill alone already gates matching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            fill <= '0;
        end else if (flush) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= (hist << 1) | DEPTH'(din);
            if (!full)
                fill <= fill + 1'b1;
        end
    end
endmodule

// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector with overlap/non-overlap modes and a
// loadable pattern. Define SEQ_DETECTOR_PARAM_CNT_EN to build the match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN  = 4,
    parameter logic [PAT_LEN-1:0] PAT_INIT = PAT_LEN'(PAT_INIT_DEF),
    parameter int                 CNT_W    = 8
) (
    input  logic               clk_bar,
    input  logic               clr_bar,
    input  logic               x,
    input  logic               x_valid,
    input  logic               overlap,
    input  logic               load,
    input  logic [PAT_LEN-1:0] pat_in,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt
);
    generate
        if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_pat_len
            $error("seq_detector_param: PAT_LEN out of range");
        end
        if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
            $error("seq_detector_param: CNT_W out of range");
        end
    endgenerate

    logic [PAT_LEN-1:0] pattern;
    logic [PAT_LEN-2:0] hist;
    logic               full;
    logic               accept;
    logic               hit;

    // A load edge discards the bit presented with it.
    assign accept = x_valid & ~load;
    assign hit    = accept & full & ({hist, x} == pattern);

    seq_shift_reg #(
        .DEPTH (PAT_LEN - 1)
    ) u_hist (
        .clk      (clk_bar),
        .rst_n    (clr_bar),
        .shift_en (accept),
        .din      (x),
        .flush    (load | (hit & (overlap == NOVL))),
        .hist     (hist),
        .full     (full)
    );

    always_ff @(posedge clk_bar or negedge clr_bar) begin
        if (!clr_bar) begin
            pattern <= PAT_INIT;
            z       <= 1'b0;
        end else begin
            z <= hit;
            if (load)
                pattern <= pat_in;
        end
    end

`ifdef SEQ_DETECTOR_PARAM_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_bar or negedge clr_bar) begin
        if (!clr_bar)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (hit && cnt != '1)
            cnt <= cnt + 1'b1;
    end

    assign match_cnt = cnt;
`else
    assign match_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench: two detectors (CNT_W=8 and CNT_W=2) share one stimulus
// stream and are checked every cycle against a bit-window model.
module tb_seq_detector_param;
    localparam int PL = 4;
`ifdef SEQ_DETECTOR_PARAM_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic          clk_bar = 1'b0;
    logic          clr_bar = 1'b1;
    logic          x = 1'b0;
    logic          x_valid = 1'b0;
    logic          overlap = 1'b1;
    logic          load = 1'b0;
    logic [PL-1:0] pat_in = '0;
    logic          z8, z2;
    logic [7:0]    cnt8;
    logic [1:0]    cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk_bar = ~clk_bar;

    seq_detector_param #(.PAT_LEN(PL), .PAT_INIT(4'b1011), .CNT_W(8)) dut8 (
        .clk_bar(clk_bar), .clr_bar(clr_bar), .x(x), .x_valid(x_valid),
        .overlap(overlap), .load(load), .pat_in(pat_in), .z(z8), .match_cnt(cnt8));

    seq_detector_param #(.PAT_LEN(PL), .PAT_INIT(4'b1011), .CNT_W(2)) dut2 (
        .clk_bar(clk_bar), .clr_bar(clr_bar), .x(x), .x_valid(x_valid),
        .overlap(overlap), .load(load), .pat_in(pat_in), .z(z2), .match_cnt(cnt2));

    // Model: window of accepted bits plus a count of bits accepted since the
    // last reset/load/non-overlapping match.
    logic [15:0]   m_bits = '0;
    logic [PL-1:0] m_pat = 4'b1011;
    int            m_fresh = 0;
    logic          m_z = 1'b0;
    int            m_cnt8 = 0;
    int            m_cnt2 = 0;

    always @(posedge clk_bar or negedge clr_bar) begin
        if (!clr_bar) begin
            m_bits = '0; m_pat = 4'b1011; m_fresh = 0; m_z = 1'b0;
            m_cnt8 = 0; m_cnt2 = 0;
        end else begin
            m_z = 1'b0;
            if (load) begin
                m_pat = pat_in; m_fresh = 0; m_cnt8 = 0; m_cnt2 = 0;
            end else if (x_valid) begin
                m_bits = {m_bits[14:0], x};
                m_fresh++;
                if (m_fresh >= PL && m_bits[PL-1:0] == m_pat) begin
                    m_z = 1'b1;
                    if (m_cnt8 < 255) m_cnt8++;
                    if (m_cnt2 < 3) m_cnt2++;
                    if (!overlap) m_fresh = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_bar) begin
        chk("z8", int'(z8), int'(m_z));
        chk("z2", int'(z2), int'(m_z));
        chk("cnt8", int'(cnt8), CNT_ON ? m_cnt8 : 0);
        chk("cnt2", int'(cnt2), CNT_ON ? m_cnt2 : 0);
    end

    task automatic send(input logic b, input logic v);
        x = b; x_valid = v;
        @(posedge clk_bar); #1;
    endtask

    task automatic do_load(input logic [PL-1:0] p, input logic b);
        load = 1'b1; pat_in = p; x = b; x_valid = 1'b1;
        @(posedge clk_bar); #1;
        load = 1'b0; x_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk_bar); #2;
        clr_bar = 1'b0; #1;
        chk("rst_z", int'(z8), 0);
        chk("rst_cnt", int'(cnt8), 0);
        @(posedge clk_bar); #2;
        clr_bar = 1'b1;
    endtask

    logic [12:0] stream7;
    logic [12:0] stream13;
    int pulses;
    int sat_exp [4] = '{1, 2, 3, 3};

    initial begin
        stream7  = 13'b1011011;
        stream13 = 13'b1011011011011;
        #2 clr_bar = 1'b0;
        #1;
        chk("init_z", int'(z8), 0);
        chk("init_cnt", int'(cnt8), 0);
        @(posedge clk_bar); #2 clr_bar = 1'b1;

        // Overlapping: pulses after bits 4 and 7
        overlap = 1'b1; pulses = 0;
        for (int i = 6; i >= 0; i--) begin
            send(stream7[i], 1'b1);
            pulses += int'(z8);
            if (i == 3 || i == 0) chk("ovl_z_hit", int'(z8), 1);
        end
        chk("ovl_pulses", pulses, 2);
        chk("ovl_cnt", int'(cnt8), CNT_ON ? 2 : 0);
        send(1'b0, 1'b0);

        // Non-overlapping: only after bit 4
        do_reset();
        overlap = 1'b0; pulses = 0;
        for (int i = 6; i >= 0; i--) begin
            send(stream7[i], 1'b1);
            pulses += int'(z8);
        end
        chk("novl_pulses", pulses, 1);
        chk("novl_cnt", int'(cnt8), CNT_ON ? 1 : 0);
        send(1'b0, 1'b0);

        // Load wins over data; counter cleared, then 0110 detected once
        do_load(4'b0110, 1'b1);
        chk("load_z", int'(z8), 0);
        chk("load_cnt", int'(cnt8), 0);
        pulses = 0;
        send(1'b0, 1'b1); pulses += int'(z8);
        send(1'b1, 1'b1); pulses += int'(z8);
        send(1'b1, 1'b1); pulses += int'(z8);
        send(1'b0, 1'b1); pulses += int'(z8);
        chk("load_last_z", int'(z8), 1);
        chk("load_pulses", pulses, 1);
        // A discarded 0 must not complete 0110 with the following 1,1,0
        do_load(4'b0110, 1'b0);
        pulses = 0;
        send(1'b1, 1'b1); pulses += int'(z8);
        send(1'b1, 1'b1); pulses += int'(z8);
        send(1'b0, 1'b1); pulses += int'(z8);
        chk("discard_pulses", pulses, 0);

        // Gaps in x_valid hold progress
        do_reset();
        overlap = 1'b1;
        send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 1'b0);
            chk("gap_z", int'(z8), 0);
        end
        send(1'b1, 1'b1);
        chk("gap_match", int'(z8), 1);

        // Asynchronous reset mid-pattern discards progress
        send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b1);
        #2 clr_bar = 1'b0;
        #1 chk("async_z", int'(z8), 0);
        chk("async_cnt", int'(cnt8), 0);
        #2 clr_bar = 1'b1;
        send(1'b1, 1'b1);
        chk("post_rst_nomatch", int'(z8), 0);

        // Saturation on the 2-bit counter
        do_reset();
        overlap = 1'b1;
        for (int i = 12; i >= 0; i--) begin
            send(stream13[i], 1'b1);
            if (i % 3 == 0)
                chk("sat_cnt2", int'(cnt2), CNT_ON ? sat_exp[3 - i / 3] : 0);
        end
        chk("sat_cnt8", int'(cnt8), CNT_ON ? 4 : 0);

        // Random tail: mode flips, gaps and occasional loads
        for (int i = 0; i < 400; i++) begin
            overlap = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0)
                do_load(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            else
                send(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        end

        @(negedge clk_bar); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
